// File: rtl/circ_buf_pkg.sv
// Shared types and helpers for the circular-buffer memory engines.
// The byte-range mask helper is used by both the write and read sides.
package circ_buf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } circ_buf_mem_wr_state_e;

   localparam int DEF_DATA_W = 256;
   localparam int DEF_BYTES  = DEF_DATA_W / 8;
   localparam int DEF_OFF_W  = $clog2(DEF_BYTES);

   // Widest word the mask helper supports (1024-bit beats).
   localparam int MAX_BYTES  = 128;

   // Mask with bits [hi:lo] set; callers slice the low BYTES bits.
   function automatic logic [MAX_BYTES-1:0] byte_range_mask(input int lo, input int hi);
      logic [MAX_BYTES-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         m[i] = (i >= lo) && (i <= hi);
      end
      return m;
   endfunction

endpackage

// File: rtl/circ_buf_mem_wr_datap.sv
// Word/beat counters, byte-enable generation and registered SRAM write port
// for the circular-buffer memory write engine.
module circ_buf_mem_wr_datap
   import circ_buf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = 16,
   parameter int SIZE_W = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  load_i,
   input  logic [ADDR_W-1:0]                     req_addr_i,
   input  logic [SIZE_W-1:0]                     req_size_i,
   input  logic                                  beat_i,
   input  logic [DATA_W-1:0]                     beat_data_i,
   output logic                                  last_beat_o,
   output logic                                  mem_wr_val_o,
   output logic [ADDR_W-$clog2(DATA_W/8)-1:0]    mem_wr_addr_o,
   output logic [DATA_W-1:0]                     mem_wr_data_o,
   output logic [DATA_W/8-1:0]                   mem_wr_byte_en_o
);

   localparam int BYTES  = DATA_W / 8;
   localparam int OFF_W  = $clog2(BYTES);
   localparam int WORD_W = ADDR_W - OFF_W;
   localparam int CNT_W  = SIZE_W + 1;

   logic [OFF_W-1:0]   off_q, off_d;
   logic [OFF_W-1:0]   last_off_q, last_off_d;
   logic [WORD_W-1:0]  word_q, word_d;
   logic [CNT_W-1:0]   beats_q, beats_d;
   logic               first_q, first_d;

   logic               mem_val_q, mem_val_d;
   logic [WORD_W-1:0]  mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]  mem_data_q, mem_data_d;
   logic [BYTES-1:0]   mem_be_q, mem_be_d;

   logic [CNT_W-1:0]     span;
   logic [MAX_BYTES-1:0] first_full;
   logic [MAX_BYTES-1:0] last_full;
   logic [BYTES-1:0]     beat_mask;

   assign last_beat_o = (beats_q == CNT_W'(1));

   always_comb begin
      span       = CNT_W'(req_addr_i[OFF_W-1:0]) + CNT_W'(req_size_i);
      // First beat starts at the offset; last beat ends at the final byte.
      first_full = byte_range_mask(first_q ? int'(off_q) : 0, BYTES - 1);
      last_full  = byte_range_mask(0, last_beat_o ? int'(last_off_q) : BYTES - 1);
      beat_mask  = first_full[BYTES-1:0] & last_full[BYTES-1:0];

      off_d      = off_q;
      last_off_d = last_off_q;
      word_d     = word_q;
      beats_d    = beats_q;
      first_d    = first_q;
      mem_val_d  = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      mem_be_d   = mem_be_q;

      if (load_i) begin
         off_d      = req_addr_i[OFF_W-1:0];
         word_d     = req_addr_i[ADDR_W-1:OFF_W];
         beats_d    = (span + CNT_W'(BYTES - 1)) >> OFF_W;
         last_off_d = OFF_W'(span - CNT_W'(1));
         first_d    = 1'b1;
      end else if (beat_i) begin
         mem_val_d  = 1'b1;
         mem_addr_d = word_q;
         mem_data_d = beat_data_i;
         mem_be_d   = beat_mask;
         // Natural overflow of the word counter gives the modulo-depth wrap.
         word_d     = word_q + WORD_W'(1);
         beats_d    = beats_q - CNT_W'(1);
         first_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         off_q      <= '0;
         last_off_q <= '0;
         word_q     <= '0;
         beats_q    <= '0;
         first_q    <= 1'b0;
         mem_val_q  <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         mem_be_q   <= '0;
      end else begin
         off_q      <= off_d;
         last_off_q <= last_off_d;
         word_q     <= word_d;
         beats_q    <= beats_d;
         first_q    <= first_d;
         mem_val_q  <= mem_val_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         mem_be_q   <= mem_be_d;
      end
   end

   assign mem_wr_val_o     = mem_val_q;
   assign mem_wr_addr_o    = mem_addr_q;
   assign mem_wr_data_o    = mem_data_q;
   assign mem_wr_byte_en_o = mem_be_q;

endmodule

// File: rtl/circ_buf_mem_wr.sv
// Memory-side write engine for a circular buffer: takes one (addr, size)
// request and its data beats, writes them to SRAM, then pulses done.
module circ_buf_mem_wr
   import circ_buf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = 16,
   parameter int SIZE_W = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  wr_buf_wr_mem_req_val,
   input  logic [ADDR_W-1:0]                     wr_buf_wr_mem_req_addr,
   input  logic [SIZE_W-1:0]                     wr_buf_wr_mem_req_size,
   output logic                                  wr_mem_wr_buf_req_rdy,
   input  logic                                  wr_buf_wr_mem_req_data_val,
   input  logic [DATA_W-1:0]                     wr_buf_wr_mem_req_data,
   output logic                                  wr_mem_wr_buf_req_data_rdy,
   output logic                                  wr_mem_wr_buf_wr_req_done,
   input  logic                                  wr_buf_wr_mem_wr_req_done_rdy,
   output logic                                  mem_wr_val,
   output logic [ADDR_W-$clog2(DATA_W/8)-1:0]    mem_wr_addr,
   output logic [DATA_W-1:0]                     mem_wr_data,
   output logic [DATA_W/8-1:0]                   mem_wr_byte_en
);

   // Handshakes: a transfer happens on a rising clk edge where valid and
   // ready are both high; ready depends only on state, never on valid.
   circ_buf_mem_wr_state_e state_q, state_d;

   logic req_fire;
   logic data_fire;
   logic last_beat;

   always_comb begin
      wr_mem_wr_buf_req_rdy      = 1'b0;
      wr_mem_wr_buf_req_data_rdy = 1'b0;
      wr_mem_wr_buf_wr_req_done  = 1'b0;
      req_fire                   = 1'b0;
      data_fire                  = 1'b0;
      state_d                    = state_q;

      case (state_q)
         ST_IDLE: begin
            wr_mem_wr_buf_req_rdy = 1'b1;
            if (wr_buf_wr_mem_req_val) begin
               req_fire = 1'b1;
               state_d  = (wr_buf_wr_mem_req_size == '0) ? ST_DONE : ST_DATA;
            end
         end
         ST_DATA: begin
            wr_mem_wr_buf_req_data_rdy = 1'b1;
            if (wr_buf_wr_mem_req_data_val) begin
               data_fire = 1'b1;
               if (last_beat) state_d = ST_FLUSH;
            end
         end
         // The final SRAM write is on the port this cycle; done follows it.
         ST_FLUSH: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            wr_mem_wr_buf_wr_req_done = 1'b1;
            if (wr_buf_wr_mem_wr_req_done_rdy) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   circ_buf_mem_wr_datap #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .SIZE_W (SIZE_W)
   ) u_datap (
      .clk              (clk),
      .rst              (rst),
      .load_i           (req_fire),
      .req_addr_i       (wr_buf_wr_mem_req_addr),
      .req_size_i       (wr_buf_wr_mem_req_size),
      .beat_i           (data_fire),
      .beat_data_i      (wr_buf_wr_mem_req_data),
      .last_beat_o      (last_beat),
      .mem_wr_val_o     (mem_wr_val),
      .mem_wr_addr_o    (mem_wr_addr),
      .mem_wr_data_o    (mem_wr_data),
      .mem_wr_byte_en_o (mem_wr_byte_en)
   );

endmodule

// File: tb/tb_circ_buf_mem_wr.sv
// Bench for circ_buf_mem_wr: directed and random requests with an expected
// SRAM-write queue checked against the memory port.
module tb_circ_buf_mem_wr;

   localparam int DATA_W = 256;
   localparam int ADDR_W = 16;
   localparam int SIZE_W = 16;
   localparam int BYTES  = 32;
   localparam int WORD_W = 11;
   localparam int DEPTH  = 2048;
   localparam int ENT_W  = WORD_W + BYTES + DATA_W;

   logic               clk;
   logic               rst;
   logic               req_val;
   logic [ADDR_W-1:0]  req_addr;
   logic [SIZE_W-1:0]  req_size;
   logic               req_rdy;
   logic               data_val;
   logic [DATA_W-1:0]  data;
   logic               data_rdy;
   logic               done;
   logic               done_rdy;
   logic               mem_wr_val;
   logic [WORD_W-1:0]  mem_wr_addr;
   logic [DATA_W-1:0]  mem_wr_data;
   logic [BYTES-1:0]   mem_wr_byte_en;

   int n_checks = 0;
   int n_errors = 0;

   logic [ENT_W-1:0] exp_q[$];
   logic [ENT_W-1:0] mon_e;

   circ_buf_mem_wr #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .SIZE_W (SIZE_W)
   ) dut (
      .clk                           (clk),
      .rst                           (rst),
      .wr_buf_wr_mem_req_val         (req_val),
      .wr_buf_wr_mem_req_addr        (req_addr),
      .wr_buf_wr_mem_req_size        (req_size),
      .wr_mem_wr_buf_req_rdy         (req_rdy),
      .wr_buf_wr_mem_req_data_val    (data_val),
      .wr_buf_wr_mem_req_data        (data),
      .wr_mem_wr_buf_req_data_rdy    (data_rdy),
      .wr_mem_wr_buf_wr_req_done     (done),
      .wr_buf_wr_mem_wr_req_done_rdy (done_rdy),
      .mem_wr_val                    (mem_wr_val),
      .mem_wr_addr                   (mem_wr_addr),
      .mem_wr_data                   (mem_wr_data),
      .mem_wr_byte_en                (mem_wr_byte_en)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                        input logic [DATA_W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Byte b of beat k is enabled when its offset from the word-aligned
   // start lies inside [off, off+size).
   function automatic logic [BYTES-1:0] model_be(input int off, input int size, input int k);
      logic [BYTES-1:0] be;
      int pos;
      for (int j = 0; j < BYTES; j++) begin
         pos   = k * BYTES + j;
         be[j] = (pos >= off) && (pos < off + size);
      end
      return be;
   endfunction

   function automatic logic [DATA_W-1:0] rand_beat();
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
      return d;
   endfunction

   // Scoreboard: every SRAM write must match the head of the expected queue.
   always @(negedge clk) begin
      if (mem_wr_val === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_wr", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", DATA_W'(mem_wr_addr), DATA_W'(mon_e[ENT_W-1 -: WORD_W]));
            check("wr_be", DATA_W'(mem_wr_byte_en), DATA_W'(mon_e[DATA_W +: BYTES]));
            check("wr_data", mem_wr_data, mon_e[DATA_W-1:0]);
         end
      end
   end

   // Driver tasks
   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic send_req(input int addr, input int size);
      logic acc;
      acc      = 1'b0;
      req_val  = 1'b1;
      req_addr = ADDR_W'(addr);
      req_size = SIZE_W'(size);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         acc = req_rdy;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      req_val = 1'b0;
      if (!acc) check("req_timeout", 0, 1);
   endtask

   task automatic send_beat(input logic [DATA_W-1:0] d);
      logic acc;
      acc      = 1'b0;
      data_val = 1'b1;
      data     = d;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         acc = data_rdy;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      data_val = 1'b0;
      if (!acc) check("data_timeout", 0, 1);
   endtask

   task automatic finish_done(input int hold);
      for (int i = 0; i < hold; i++) begin
         check("done_hold", done, 1);
         check("req_rdy_in_done", req_rdy, 0);
         check("data_rdy_in_done", data_rdy, 0);
         @(posedge clk);
         #1;
      end
      check("done_before_ack", done, 1);
      done_rdy = 1'b1;
      @(posedge clk);
      #1;
      done_rdy = 1'b0;
      check("idle_req_rdy", req_rdy, 1);
      check("idle_done", done, 0);
   endtask

   task automatic run_req(input int addr, input int size, input int max_stall, input int hold);
      int off, word, beats;
      logic [DATA_W-1:0] d;
      off   = addr % BYTES;
      word  = addr / BYTES;
      beats = (off + size + BYTES - 1) / BYTES;
      send_req(addr, size);
      if (size == 0) begin
         check("zero_done", done, 1);
         check("zero_no_wr", mem_wr_val, 0);
      end else begin
         for (int k = 0; k < beats; k++) begin
            repeat ($urandom_range(0, max_stall)) begin
               @(posedge clk);
               #1;
            end
            d = rand_beat();
            exp_q.push_back({WORD_W'((word + k) % DEPTH), model_be(off, size, k), d});
            send_beat(d);
         end
         check("done_not_yet", done, 0);
         @(posedge clk);
         #1;
         check("done_at_t2", done, 1);
      end
      finish_done(hold);
   endtask

   initial begin
      logic [DATA_W-1:0] d;
      rst      = 1'b0;
      req_val  = 1'b0;
      req_addr = '0;
      req_size = '0;
      data_val = 1'b0;
      data     = '0;
      done_rdy = 1'b0;

      do_reset();
      check("rst_req_rdy", req_rdy, 1);
      check("rst_data_rdy", data_rdy, 0);
      check("rst_done", done, 0);
      check("rst_wr_val", mem_wr_val, 0);
      check("rst_wr_addr", DATA_W'(mem_wr_addr), 0);
      check("rst_wr_data", mem_wr_data, 0);
      check("rst_wr_be", DATA_W'(mem_wr_byte_en), 0);

      // Aligned two-beat request with fixed patterns.
      send_req(16'h0000, 64);
      d = {BYTES{8'hAA}};
      exp_q.push_back({WORD_W'(0), 32'hFFFF_FFFF, d});
      send_beat(d);
      d = {BYTES{8'hBB}};
      exp_q.push_back({WORD_W'(1), 32'hFFFF_FFFF, d});
      send_beat(d);
      check("aligned_done_t1", done, 0);
      @(posedge clk);
      #1;
      check("aligned_done_t2", done, 1);
      finish_done(0);

      run_req(16'h0005, 10, 0, 0);   // single unaligned beat
      run_req(16'h001C, 8, 1, 1);    // straddles two words
      run_req(16'hFFF0, 32, 2, 0);   // wraps word 2047 -> 0
      run_req(16'h0100, 0, 0, 5);    // zero size, done held 5 cycles

      // Reset after the first of three beats.
      send_req(16'h0040, 96);
      d = rand_beat();
      exp_q.push_back({WORD_W'(2), 32'hFFFF_FFFF, d});
      send_beat(d);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      check("midrst_req_rdy", req_rdy, 1);
      check("midrst_data_rdy", data_rdy, 0);
      check("midrst_done", done, 0);
      check("midrst_wr_val", mem_wr_val, 0);
      check("midrst_wr_addr", DATA_W'(mem_wr_addr), 0);
      check("midrst_wr_data", mem_wr_data, 0);
      check("midrst_wr_be", DATA_W'(mem_wr_byte_en), 0);
      data_val = 1'b1;
      data     = rand_beat();
      repeat (3) begin
         @(negedge clk);
         check("refused_beat", data_rdy, 0);
         @(posedge clk);
         #1;
      end
      data_val = 1'b0;

      // Random requests, back-to-back after each done.
      for (int n = 0; n < 10; n++) begin
         run_req($urandom_range(0, 65535), $urandom_range(0, 150),
                 $urandom_range(0, 2), $urandom_range(0, 3));
      end

      repeat (3) @(posedge clk);
      check("sb_empty", DATA_W'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
